// File: rtl/pc_ras_unit.sv
// Next-PC generator with a circular return-address stack (RAS).
// pc is registered; CALL pushes pc+4, RET pops, and full/empty/sticky flags track the RAS.
module pc_ras_unit #(
  parameter int                WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VEC = '0,
  parameter logic [WIDTH-1:0]  TRAP_VEC  = WIDTH'(32'h100),
  parameter int                RAS_DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       enable_i,
  input  logic                       flush_i,
  input  logic [2:0]                 op_i,
  input  logic [WIDTH-1:0]           target_i,
  input  logic [WIDTH-1:0]           offset_i,
  output logic [WIDTH-1:0]           pc_o,
  output logic                       redirect_o,
  output logic [$clog2(RAS_DEPTH):0] ras_count_o,
  output logic                       ras_full_o,
  output logic                       ras_empty_o,
  output logic                       ras_ovf_o,
  output logic                       ras_unf_o
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] OP_SEQ    = 3'd0;
  localparam logic [2:0] OP_BRANCH = 3'd1;
  localparam logic [2:0] OP_JUMP   = 3'd2;
  localparam logic [2:0] OP_CALL   = 3'd3;
  localparam logic [2:0] OP_RET    = 3'd4;
  localparam logic [2:0] OP_TRAP   = 3'd5;

  logic [WIDTH-1:0] pc_q, pc_d, nxt_pc, seq_pc;
  logic             redir_q, redir_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_f;
  logic [PW-1:0]    ptr_q, ptr_d, ptr_f, rd_idx;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             push;
  logic [WIDTH-1:0] stack_q [RAS_DEPTH];

  // Flush takes effect before this cycle's op, so ops see the cleared stack.
  always_comb begin
    cnt_f   = flush_i ? '0 : cnt_q;
    ptr_f   = flush_i ? '0 : ptr_q;
    rd_idx  = ptr_f - PW'(1);
    seq_pc  = pc_q + WIDTH'(4);
    nxt_pc  = pc_q;
    push    = 1'b0;
    ptr_d   = ptr_f;
    cnt_d   = cnt_f;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    redir_d = 1'b0;
    case (op_i)
      OP_SEQ:    nxt_pc = seq_pc;
      OP_BRANCH: begin nxt_pc = pc_q + offset_i; redir_d = 1'b1; end
      OP_JUMP:   begin nxt_pc = target_i;        redir_d = 1'b1; end
      OP_CALL: begin
        nxt_pc  = target_i;
        redir_d = 1'b1;
        push    = 1'b1;
        ptr_d   = ptr_f + PW'(1);
        // When full the write pointer already sits on the oldest entry.
        if (cnt_f == CW'(RAS_DEPTH)) ovf_d = 1'b1;
        else                         cnt_d = cnt_f + CW'(1);
      end
      OP_RET: begin
        redir_d = 1'b1;
        if (cnt_f != '0) begin
          nxt_pc = stack_q[rd_idx];
          ptr_d  = rd_idx;
          cnt_d  = cnt_f - CW'(1);
        end else begin
          nxt_pc = target_i;
          unf_d  = 1'b1;
        end
      end
      OP_TRAP:   begin nxt_pc = TRAP_VEC; redir_d = 1'b1; end
      default:   nxt_pc = pc_q;
    endcase
    pc_d = {nxt_pc[WIDTH-1:2], 2'b00};
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pc_q    <= {RESET_VEC[WIDTH-1:2], 2'b00};
      redir_q <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (enable_i) begin
      pc_q    <= pc_d;
      redir_q <= redir_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enable_i && push && !reset_i) stack_q[ptr_f] <= seq_pc;
  end

  assign pc_o        = pc_q;
  assign redirect_o  = redir_q;
  assign ras_count_o = cnt_q;
  assign ras_full_o  = (cnt_q == CW'(RAS_DEPTH));
  assign ras_empty_o = (cnt_q == '0);
  assign ras_ovf_o   = ovf_q;
  assign ras_unf_o   = unf_q;
endmodule

// File: doc/pc_ras_unit.md
PC_RAS_UNIT -- requirements
Module: pc_ras_unit

Interface
REQ-001 Parameter WIDTH, default 32: PC and address width in bits, minimum 8.
REQ-002 Parameter RESET_VEC, default 0: PC value after reset.
REQ-003 Parameter TRAP_VEC, default 'h100: PC value loaded by a TRAP op.
REQ-004 Parameter RAS_DEPTH, default 4: number of return-address stack entries, a power of two, minimum 2.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-007 enable  in  1  1 = perform op this cycle; 0 = hold all state.
REQ-008 flush  in  1  synchronous RAS clear; qualified by enable.
REQ-009 op  in  3  next-PC select: 0 SEQ, 1 BRANCH, 2 JUMP, 3 CALL, 4 RET, 5 TRAP, 6 HOLD, 7 HOLD.
REQ-010 target  in  WIDTH  absolute address for JUMP/CALL; fallback address for RET.
REQ-011 offset  in  WIDTH  two's-complement displacement for BRANCH.
REQ-012 pc  out  WIDTH  registered current PC.
REQ-013 redirect  out  1  registered; 1 for the cycle after any accepted non-SEQ, non-HOLD op.
REQ-014 ras_count  out  $clog2(RAS_DEPTH)+1  number of valid RAS entries.
REQ-015 ras_full / ras_empty  out  1 each  combinational decodes: count==RAS_DEPTH / count==0.
REQ-016 ras_ovf / ras_unf  out  1 each  sticky overflow / underflow flags.

Function
REQ-017 All updates occur only on a rising clk edge with enable=1; with enable=0, pc, RAS, flags and redirect hold their values.
REQ-018 PC latency is one cycle: pc reflects an accepted op on the edge that accepts it.
REQ-019 SEQ: pc <= pc+4.
REQ-020 BRANCH: pc <= pc+offset.
REQ-021 JUMP: pc <= target.
REQ-022 CALL: push pc+4 onto the RAS; pc <= target.
REQ-023 RET with count>0: pop the top entry; pc <= popped value.
REQ-024 RET with count==0: pc <= target; set ras_unf; count stays 0.
REQ-025 TRAP: pc <= TRAP_VEC; RAS unchanged.
REQ-026 HOLD (op 6 or 7): pc unchanged; no RAS activity; redirect <= 0.
REQ-027 Address arithmetic is modulo 2^WIDTH; carries are discarded silently.
REQ-028 Every value loaded into pc, including RESET_VEC and TRAP_VEC, has bits [1:0] forced to 0.
REQ-029 The RAS is circular: a write pointer and a count register; push writes at the pointer and increments it, pop decrements the pointer first, then reads.
REQ-030 CALL when full: overwrite the oldest entry; count stays RAS_DEPTH; set ras_ovf.
REQ-031 flush=1 with enable=1: count <= 0 and pointer <= 0, applied before that cycle's op, so flush+CALL leaves count=1 holding pc+4, and flush+RET takes the underflow path.
REQ-032 flush does not clear ras_ovf or ras_unf; only reset clears the sticky flags.
REQ-033 redirect <= 1 after an accepted BRANCH, JUMP, CALL, RET or TRAP, including BRANCH with offset 0; redirect <= 0 after SEQ or HOLD.

Reset
REQ-034 While reset=1, regardless of clk, the block holds: pc=RESET_VEC with bits [1:0] cleared, redirect=0, ras_count=0, pointer=0, ras_ovf=0, ras_unf=0.
REQ-035 Reset asserted mid-operation aborts any pending push or pop; RAS entry contents need not be cleared.
REQ-036 The first op is accepted on the first rising edge after reset deasserts.

Verification
REQ-037 Reset, then 3 SEQ cycles -> pc 0,4,8,12; redirect stays 0.
REQ-038 pc=0x10; BRANCH offset=0xFFFFFFF0 -> pc=0x0, redirect=1; BRANCH offset=0xFFFFFFFC at pc=0 -> pc=0xFFFFFFFC (wrap).
REQ-039 CALL target=0x200 at pc=0x40, then RET -> pc=0x200, count=1, then pc=0x44, count=0; RET again with target=0x300 -> pc=0x300, ras_unf=1.
REQ-040 Five CALLs with RAS_DEPTH=4 from pcs A..E -> ras_ovf=1, count=4; four RETs return E+4, D+4, C+4, B+4; a fifth RET underflows.
REQ-041 enable=0 with op=JUMP -> no change; flush+CALL with count=3 -> count=1; JUMP target=0x203 -> pc=0x200.
REQ-042 Assert reset asynchronously between clock edges during a CALL stream -> pc=RESET_VEC, flags cleared before the next edge.
